// File: rtl/seq_normalizer_pkg.sv
// Shared definitions for the sequential left-normalizer: state encodings and
// the count-width helper.
package seq_normalizer_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Count must be able to represent WIDTH itself (all-zero word).
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_normalizer_if.sv
// Valid/ready bus between the upstream stage, the normalizer and its consumer.
// master = environment side, slave = normalizer side.
interface seq_normalizer_if
  import seq_normalizer_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = cnt_w(WIDTH)
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] out_lz;
  logic             out_zero;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_lz, out_zero
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_lz, out_zero
  );

endinterface

// File: rtl/seq_normalizer.sv
// Sequential left-normalizer: shifts an accepted word left one bit per clock
// until its MSB is set, reporting the shift (leading-zero) count.
module seq_normalizer
  import seq_normalizer_pkg::*;
#(
  parameter int WIDTH = 4,
  localparam int CNT_W = cnt_w(WIDTH)
) (
  input  logic            clk,
  input  logic            rst,
  seq_normalizer_if.slave bus
);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic [CNT_W-1:0] lz_q,    lz_d;
  logic             zero_q,  zero_d;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    lz_d    = lz_q;
    zero_d  = zero_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          data_d = bus.in_data;
          lz_d   = '0;
          zero_d = 1'b0;
          if (bus.in_data == '0) begin
            zero_d  = 1'b1;
            lz_d    = CNT_W'(WIDTH);
            data_d  = '0;
            state_d = ST_DONE;
          end else if (bus.in_data[WIDTH-1]) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        data_d = data_q << 1;
        lz_d   = lz_q + CNT_W'(1);
        // Leave on the edge that brings the next-highest bit into the MSB.
        if (data_q[WIDTH-2]) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      lz_q    <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      lz_q    <= lz_d;
      zero_q  <= zero_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.out_data  = data_q;
  assign bus.out_lz    = lz_q;
  assign bus.out_zero  = zero_q;

endmodule

// File: tb/tb_seq_normalizer.sv
// Self-checking bench for seq_normalizer (WIDTH=4): directed table, hand-written
// corner sequences and a randomized sweep against a behavioural model.
module tb_seq_normalizer;

  localparam int W = 4;
  localparam int C = 3;

  typedef struct {
    logic [W-1:0] in_data;
    int           stall;
    logic [W-1:0] exp_data;
    logic [C-1:0] exp_lz;
    logic         exp_zero;
    int           exp_lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   tests_run = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  seq_normalizer_if #(.WIDTH(W)) bus ();

  seq_normalizer #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic checkOutput(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Behavioural reference: count zeros from the MSB, shift them out.
  // Latency is counted in edges including the acceptance edge: one edge to
  // leave IDLE, plus one edge per shift when the word needs shifting.
  function automatic void refModel(input logic [W-1:0] d, output logic [W-1:0] nd,
                                   output logic [C-1:0] lz, output logic z,
                                   output int lat);
    int n = 0;
    while (n < W && d[W-1-n] == 1'b0) n++;
    z   = (d == '0);
    lz  = C'(n);
    nd  = z ? '0 : W'(d << n);
    lat = (z || n == 0) ? 1 : n + 1;
  endfunction

  task automatic waitValid(output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Called #1 after a rising edge with the DUT idle.
  task automatic applyStimulus(input logic [W-1:0] d, input int stall,
                               input logic [W-1:0] ed, input logic [C-1:0] el,
                               input logic ez, input int elat);
    int lat;
    checkOutput("in_ready_idle", int'(bus.in_ready), 1);
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.out_ready = (stall == 0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_data  = W'($urandom);
    waitValid(lat);
    checkOutput("latency", lat, elat);
    for (int i = 0; i < stall; i++) begin
      checkOutput("stall_in_ready", int'(bus.in_ready), 0);
      checkOutput("stall_data", int'(bus.out_data), int'(ed));
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    checkOutput("out_valid", int'(bus.out_valid), 1);
    checkOutput("out_data", int'(bus.out_data), int'(ed));
    checkOutput("out_lz", int'(bus.out_lz), int'(el));
    checkOutput("out_zero", int'(bus.out_zero), int'(ez));
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checkOutput("back_to_idle", int'(bus.out_valid), 0);
  endtask

  initial begin
    vec_t         vecs[7];
    logic [W-1:0] nd;
    logic [C-1:0] lz;
    logic         z;
    int           lat;
    logic [W-1:0] d;

    vecs[0] = '{4'b0001, 0, 4'b1000, 3'd3, 1'b0, 4};
    vecs[1] = '{4'b0000, 0, 4'b0000, 3'd4, 1'b1, 1};
    vecs[2] = '{4'b1011, 0, 4'b1011, 3'd0, 1'b0, 1};
    vecs[3] = '{4'b0010, 2, 4'b1000, 3'd2, 1'b0, 3};
    vecs[4] = '{4'b0100, 1, 4'b1000, 3'd1, 1'b0, 2};
    vecs[5] = '{4'b0111, 0, 4'b1110, 3'd1, 1'b0, 2};
    vecs[6] = '{4'b0011, 3, 4'b1100, 3'd2, 1'b0, 3};

    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checkOutput("reset_out_valid", int'(bus.out_valid), 0);
    checkOutput("reset_out_data", int'(bus.out_data), 0);
    checkOutput("reset_out_lz", int'(bus.out_lz), 0);
    checkOutput("reset_out_zero", int'(bus.out_zero), 0);
    checkOutput("reset_in_ready", int'(bus.in_ready), 1);

    for (int i = 0; i < 7; i++)
      applyStimulus(vecs[i].in_data, vecs[i].stall, vecs[i].exp_data,
                    vecs[i].exp_lz, vecs[i].exp_zero, vecs[i].exp_lat);

    // Long stall, then in_valid together with out_ready in DONE.
    bus.in_valid  = 1'b1;
    bus.in_data   = 4'b0010;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    waitValid(lat);
    checkOutput("hold_latency", lat, 3);
    repeat (5) begin
      @(posedge clk); #1;
      checkOutput("hold_data", int'(bus.out_data), 4'b1000);
      checkOutput("hold_lz", int'(bus.out_lz), 2);
      checkOutput("hold_in_ready", int'(bus.in_ready), 0);
      checkOutput("hold_valid", int'(bus.out_valid), 1);
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 4'b0001;
    @(posedge clk); #1;
    checkOutput("done_no_accept_valid", int'(bus.out_valid), 0);
    checkOutput("done_no_accept_ready", int'(bus.in_ready), 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    checkOutput("next_accept_busy", int'(bus.in_ready), 0);
    waitValid(lat);
    checkOutput("next_latency", lat, 4);
    checkOutput("next_data", int'(bus.out_data), 4'b1000);
    checkOutput("next_lz", int'(bus.out_lz), 3);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checkOutput("next_idle", int'(bus.in_ready), 1);

    // Reset in the middle of a shift discards the word immediately.
    bus.in_valid = 1'b1;
    bus.in_data  = 4'b0001;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checkOutput("midrst_out_valid", int'(bus.out_valid), 0);
    checkOutput("midrst_in_ready", int'(bus.in_ready), 1);
    checkOutput("midrst_out_data", int'(bus.out_data), 0);
    checkOutput("midrst_out_lz", int'(bus.out_lz), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    applyStimulus(4'b0100, 0, 4'b1000, 3'd1, 1'b0, 2);

    // Full sweep plus random words with random consumer stalls.
    for (int v = 0; v < 16 + 24; v++) begin
      d = (v < 16) ? W'(v) : W'($urandom);
      refModel(d, nd, lz, z, lat);
      applyStimulus(d, int'($urandom_range(0, 3)), nd, lz, z, lat);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
